data_sync_ctrl: RTL and testbench

Destination-domain controller for multi-bit clock-domain crossing: synchronizes a source-side bus-enable level through an internal NUM_STAGES flip-flop chain, detects its rising edge, and captures the quasi-static source bus into a 2-entry output queue. The queue is drained through a valid/ready handshake to the destination logic. The block also reports dropped transfers and counts accepted ones. It sits at every bus-crossing boundary of the multi-clock system, on the receiving side.

---
 rtl/data_sync_ctrl.sv | 109 ++++++++++
 tb/tb_data_sync_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_ctrl.sv
// Receive-side bus CDC: enable synchronizer, rising-edge capture into a 2-entry queue; capture NUM_STAGES+1 CLK after enable.
// Queue drains on SYNC_VALID & SYNC_READY; a capture arriving while full is dropped and flagged on OVERFLOW.
module data_sync_ctrl #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 SYNC_VALID,
  input  logic                 SYNC_READY,
  output logic                 ENABLE_PULSE,
  output logic                 OVERFLOW,
  input  logic                 CLR_OVF,
  output logic [7:0]           XFER_CNT
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} q_state_t;

  q_state_t               state_q, state_d;
  logic [NUM_STAGES-1:0]  sync_q;
  logic                   en_prev;
  logic [BUS_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic                   rise, pop, accept, drop;

  assign rise = sync_q[NUM_STAGES-1] & ~en_prev;
  assign pop  = (state_q != EMPTY) & SYNC_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      en_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
      en_prev <= sync_q[NUM_STAGES-1];
    end
  end

  // UNSYNC_BUS is only read on the rise cycle, when the source guarantees it is stable.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (rise) begin
          state_d = ONE;
          head_d  = UNSYNC_BUS;
          accept  = 1'b1;
        end
      end
      ONE: begin
        if (rise && pop) begin
          head_d = UNSYNC_BUS;
          accept = 1'b1;
        end else if (rise) begin
          state_d = TWO;
          tail_d  = UNSYNC_BUS;
          accept  = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (rise && pop) begin
          head_d = tail_q;
          tail_d = UNSYNC_BUS;
          accept = 1'b1;
        end else if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end else if (rise) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
      ENABLE_PULSE <= 1'b0;
      OVERFLOW     <= 1'b0;
      XFER_CNT     <= 8'd0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      ENABLE_PULSE <= accept;
      XFER_CNT     <= XFER_CNT + 8'(accept);
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)
        OVERFLOW <= 1'b1;
      else if (CLR_OVF)
        OVERFLOW <= 1'b0;
    end
  end

  assign SYNC_VALID = (state_q != EMPTY);
  assign SYNC_BUS   = head_q;

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Directed bench for data_sync_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_data_sync_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] UNSYNC_BUS = 8'h00;
  logic       BUS_ENABLE = 1'b0;
  logic [7:0] SYNC_BUS;
  logic       SYNC_VALID;
  logic       SYNC_READY = 1'b0;
  logic       ENABLE_PULSE;
  logic       OVERFLOW;
  logic       CLR_OVF = 1'b0;
  logic [7:0] XFER_CNT;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  data_sync_ctrl #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .UNSYNC_BUS(UNSYNC_BUS), .BUS_ENABLE(BUS_ENABLE),
    .SYNC_BUS(SYNC_BUS), .SYNC_VALID(SYNC_VALID), .SYNC_READY(SYNC_READY),
    .ENABLE_PULSE(ENABLE_PULSE), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF),
    .XFER_CNT(XFER_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
    if (ENABLE_PULSE) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic xfer(input logic [7:0] d);
    UNSYNC_BUS = d;
    BUS_ENABLE = 1'b1;
    ticks(4);
    BUS_ENABLE = 1'b0;
    ticks(4);
  endtask

  task automatic apply_reset();
    RST = 1'b0; BUS_ENABLE = 1'b0; SYNC_READY = 1'b0; CLR_OVF = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    pulses = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    UNSYNC_BUS = 8'($urandom); BUS_ENABLE = 1'b1; SYNC_READY = 1'b1; CLR_OVF = 1'b1;
    ticks(3);
    n_cmp++; if ({SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT} !== 19'd0) begin
      n_fail++; $display("FAIL rst_hold: outs=%h want 0", {SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT}); end
    BUS_ENABLE = 1'b0; CLR_OVF = 1'b0; SYNC_READY = 1'b0;
    RST = 1'b1;
    ticks(5);
    n_cmp++; if ({SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT} !== 19'd0) begin
      n_fail++; $display("FAIL rst_release: outs=%h want 0", {SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT}); end
  endtask

  task automatic test_single();
    apply_reset();
    SYNC_READY = 1'b1;
    UNSYNC_BUS = 8'hA5;
    BUS_ENABLE = 1'b1;
    ticks(2);
    n_cmp++; if (SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL single_early: valid=%b want 0", SYNC_VALID); end
    tick();
    n_cmp++; if ({SYNC_VALID, ENABLE_PULSE} !== 2'b11) begin
      n_fail++; $display("FAIL single_lat: valid,pulse=%b want 11", {SYNC_VALID, ENABLE_PULSE}); end
    n_cmp++; if (SYNC_BUS !== 8'hA5) begin
      n_fail++; $display("FAIL single_data: bus=%h want a5", SYNC_BUS); end
    tick();
    n_cmp++; if ({SYNC_VALID, ENABLE_PULSE} !== 2'b00) begin
      n_fail++; $display("FAIL single_pop: valid,pulse=%b want 00", {SYNC_VALID, ENABLE_PULSE}); end
    n_cmp++; if (SYNC_BUS !== 8'hA5) begin
      n_fail++; $display("FAIL single_hold: bus=%h want a5", SYNC_BUS); end
    BUS_ENABLE = 1'b0;
    ticks(4);
    n_cmp++; if (XFER_CNT !== 8'd1) begin
      n_fail++; $display("FAIL single_cnt: cnt=%0d want 1", XFER_CNT); end
    n_cmp++; if (pulses !== 1) begin
      n_fail++; $display("FAIL single_pulses: pulses=%0d want 1", pulses); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    xfer(8'h11); xfer(8'h22); xfer(8'h33);
    n_cmp++; if ({SYNC_VALID, SYNC_BUS} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL fill_head: valid,bus=%h want 111", {SYNC_VALID, SYNC_BUS}); end
    n_cmp++; if (OVERFLOW !== 1'b1) begin
      n_fail++; $display("FAIL fill_ovf: ovf=%b want 1", OVERFLOW); end
    n_cmp++; if (XFER_CNT !== 8'd2) begin
      n_fail++; $display("FAIL fill_cnt: cnt=%0d want 2", XFER_CNT); end
    n_cmp++; if (pulses !== 2) begin
      n_fail++; $display("FAIL fill_pulses: pulses=%0d want 2", pulses); end
    SYNC_READY = 1'b1;
    tick();
    n_cmp++; if ({SYNC_VALID, SYNC_BUS} !== {1'b1, 8'h22}) begin
      n_fail++; $display("FAIL fill_pop1: valid,bus=%h want 122", {SYNC_VALID, SYNC_BUS}); end
    tick();
    n_cmp++; if (SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL fill_pop2: valid=%b want 0", SYNC_VALID); end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    xfer(8'h11); xfer(8'h22);
    UNSYNC_BUS = 8'h33;
    BUS_ENABLE = 1'b1;
    ticks(2);
    SYNC_READY = 1'b1;
    tick();
    SYNC_READY = 1'b0;
    n_cmp++; if ({SYNC_VALID, SYNC_BUS, ENABLE_PULSE} !== {1'b1, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL pp_head: valid,bus,pulse=%h want 245", {SYNC_VALID, SYNC_BUS, ENABLE_PULSE}); end
    n_cmp++; if ({OVERFLOW, XFER_CNT} !== {1'b0, 8'd3}) begin
      n_fail++; $display("FAIL pp_ovf_cnt: ovf,cnt=%h want 003", {OVERFLOW, XFER_CNT}); end
    tick();
    BUS_ENABLE = 1'b0;
    ticks(4);
    SYNC_READY = 1'b1;
    tick();
    n_cmp++; if ({SYNC_VALID, SYNC_BUS} !== {1'b1, 8'h33}) begin
      n_fail++; $display("FAIL pp_tail: valid,bus=%h want 133", {SYNC_VALID, SYNC_BUS}); end
    tick();
    n_cmp++; if (SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL pp_empty: valid=%b want 0", SYNC_VALID); end
    SYNC_READY = 1'b0;
  endtask

  task automatic test_ovf_clear();
    apply_reset();
    xfer(8'h44); xfer(8'h55);
    n_cmp++; if (OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL clr_pre: ovf=%b want 0", OVERFLOW); end
    UNSYNC_BUS = 8'h66;
    BUS_ENABLE = 1'b1;
    ticks(2);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    n_cmp++; if (OVERFLOW !== 1'b1) begin
      n_fail++; $display("FAIL clr_race: ovf=%b want 1", OVERFLOW); end
    tick();
    BUS_ENABLE = 1'b0;
    ticks(4);
    n_cmp++; if ({SYNC_BUS, XFER_CNT} !== {8'h44, 8'd2}) begin
      n_fail++; $display("FAIL clr_queue: bus,cnt=%h want 4402", {SYNC_BUS, XFER_CNT}); end
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    n_cmp++; if (OVERFLOW !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone: ovf=%b want 0", OVERFLOW); end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    SYNC_READY = 1'b1;
    for (int i = 0; i < 255; i++) xfer(8'(i));
    n_cmp++; if (XFER_CNT !== 8'd255) begin
      n_fail++; $display("FAIL wrap_255: cnt=%0d want 255", XFER_CNT); end
    xfer(8'hFF);
    n_cmp++; if (XFER_CNT !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0: cnt=%0d want 0", XFER_CNT); end
    SYNC_READY = 1'b0;
    UNSYNC_BUS = 8'h5A;
    BUS_ENABLE = 1'b1;
    ticks(3);
    n_cmp++; if ({SYNC_VALID, SYNC_BUS, XFER_CNT} !== {1'b1, 8'h5A, 8'd1}) begin
      n_fail++; $display("FAIL mid_pre: valid,bus,cnt=%h want 15a01", {SYNC_VALID, SYNC_BUS, XFER_CNT}); end
    RST = 1'b0;
    #1;
    n_cmp++; if ({SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT} !== 19'd0) begin
      n_fail++; $display("FAIL mid_rst: outs=%h want 0", {SYNC_BUS, SYNC_VALID, ENABLE_PULSE, OVERFLOW, XFER_CNT}); end
    ticks(2);
    RST = 1'b1;
    pulses = 0;
    ticks(2);
    n_cmp++; if (SYNC_VALID !== 1'b0) begin
      n_fail++; $display("FAIL rel_early: valid=%b want 0", SYNC_VALID); end
    tick();
    n_cmp++; if ({SYNC_VALID, ENABLE_PULSE, SYNC_BUS, XFER_CNT} !== {1'b1, 1'b1, 8'h5A, 8'd1}) begin
      n_fail++; $display("FAIL rel_cap: valid,pulse,bus,cnt=%h want 35a01", {SYNC_VALID, ENABLE_PULSE, SYNC_BUS, XFER_CNT}); end
    ticks(6);
    n_cmp++; if ({pulses, XFER_CNT} !== {32'd1, 8'd1}) begin
      n_fail++; $display("FAIL rel_once: pulses=%0d cnt=%0d want 1 1", pulses, XFER_CNT); end
    BUS_ENABLE = 1'b0;
    ticks(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop_full();
    test_ovf_clear();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
